fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, sync active-high reset.
REQ-006 SHALL have ports: imem_req_o out 1, fetch request; imem_addr_o out XLEN, fetch address.
REQ-007 SHALL have ports: imem_rvalid_i in 1, response valid; imem_rdata_i in XLEN, instruction word.
REQ-008 SHALL have ports: redirect_i in 1, redirect_pc_i in XLEN, meaning branch/jump redirect.
REQ-009 SHALL have port halt_i in 1, meaning freeze fetch and delivery.
REQ-010 SHALL have ports: valid_o out 1, pc_o out XLEN, ir_o out XLEN, ready_i in 1, meaning decode handshake.

Function
REQ-011 Memory SHALL be fixed-latency: an issued request (imem_req_o=1) is answered with imem_rvalid_i=1 exactly one cycle later.
REQ-012 imem_req_o SHALL be 1 iff ~rst, ~halt_i, ~redirect_i, and count + inflight < DEPTH (count = queue occupancy, inflight = 1 if a live request was issued last cycle).
REQ-013 imem_addr_o SHALL equal fetch_pc; fetch_pc SHALL advance by 4 (mod 2^XLEN, wraps) on each issued request.
REQ-014 Each issued request SHALL record its address as the in-flight PC; the response SHALL be enqueued as the {pc, inst} pair.
REQ-015 imem_rvalid_i with no live in-flight request SHALL be ignored.
REQ-016 valid_o SHALL be 1 iff queue non-empty and ~halt_i; pc_o/ir_o SHALL show queue head, and 0 when valid_o=0.
REQ-017 Pop SHALL occur when valid_o & ready_i; simultaneous pop and enqueue SHALL leave count unchanged, preserving order.
REQ-018 The queue SHALL never overflow; count SHALL stay within 0..DEPTH.
REQ-019 redirect_i SHALL, in that cycle: load fetch_pc <= redirect_pc_i, clear the queue, kill the in-flight request (its response next cycle is dropped), and issue no request; valid_o MAY show the old head that cycle, but no pop SHALL occur.
REQ-020 redirect_i SHALL take priority over halt_i and over any simultaneous enqueue/pop.
REQ-021 halt_i SHALL block new requests and pops; a response already in flight SHALL still be enqueued.
REQ-022 First request after reset release SHALL be issued in the first cycle with rst=0, at RESET_PC.

Reset
REQ-023 While rst=1: fetch_pc <= RESET_PC, count <= 0, inflight <= 0, imem_req_o=0, valid_o=0, pc_o=0, ir_o=0.
REQ-024 rst SHALL override redirect_i, halt_i and imem_rvalid_i; a response arriving the cycle after reset assertion SHALL be dropped.

Configuration
REQ-025 With FETCH_BYPASS_EN defined: when the queue is empty, ~halt_i, ~redirect_i and a live response arrives, valid_o/pc_o/ir_o SHALL present it combinationally the same cycle; if ready_i=1 it is consumed without enqueue, else it is enqueued.
REQ-026 Without FETCH_BYPASS_EN: every response SHALL be enqueued first, giving minimum request-to-valid_o latency of 2 cycles (1 with bypass).

Verification
REQ-027 Reset release, ready_i=1, no bypass -> requests at 0x0,0x4,0x8...; valid_o first high 2 cycles after rst falls with pc_o=0x0, ir_o=rdata.
REQ-028 ready_i=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, count=4, imem_req_o=0 until a pop; then pop order 0x0,0x4,0x8,0xC.
REQ-029 redirect_i=1, redirect_pc_i=0x100 while a request to 0x10 is in flight -> 0x10 response dropped, queue empty, next request at 0x100 the following cycle.
REQ-030 halt_i=1 for 3 cycles with one request in flight -> response enqueued, no new requests, valid_o=0; after release delivery resumes in order.
REQ-031 fetch_pc=32'hFFFF_FFFC request -> next request address 0x0 (wrap), pc tags correct.
REQ-032 FETCH_BYPASS_EN, empty queue, ready_i=1 -> valid_o high in response cycle, count stays 0.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch front end with a small {pc, inst} queue.
// Issues one fixed-latency request per cycle while the queue has room for
// everything already in flight. Decode drains the queue through a valid/ready
// port. Optional feature macro: FETCH_BYPASS_EN. When it is defined, a
// response that arrives while the queue is empty is presented to decode in
// the same cycle.
//
// Decode handshake: valid_o/pc_o/ir_o describe the current head. The entry
// is consumed on any cycle where valid_o && ready_i && !redirect_i.
// valid_o does not wait for ready_i. While valid_o=0, pc_o/ir_o are zero.
module fetch_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ir_o,
    input  logic            ready_i
);
    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam int unsigned     CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_d [DEPTH];
    logic [XLEN-1:0] ir_mem_q [DEPTH];
    logic [XLEN-1:0] ir_mem_d [DEPTH];

    logic live_rsp;
    logic empty;
    logic bypass;
    logic pop;
    logic pop_queue;
    logic enq;

    // A response is only meaningful if its request was still alive last cycle.
    assign live_rsp = imem_rvalid_i & inflight_q;
    assign empty    = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = ~rst & empty & ~halt_i & ~redirect_i & live_rsp;
`else
    assign bypass = 1'b0;
`endif

    // Room is reserved for the in-flight response, so the queue cannot overflow.
    assign imem_req_o  = ~rst & ~halt_i & ~redirect_i &
                         ((count_q + CW'(inflight_q)) < DEPTH_C);
    assign imem_addr_o = fetch_pc_q;

    assign valid_o   = ~rst & ~halt_i & (~empty | bypass);
    assign pop       = valid_o & ready_i & ~redirect_i;
    assign pop_queue = pop & ~bypass;
    // A bypassed response that decode takes immediately never touches the queue.
    assign enq       = ~rst & ~redirect_i & live_rsp & ~(bypass & ready_i);

    // Output mux: bypassed response, queue head, or zeros.
    always_comb begin
        pc_o = '0;
        ir_o = '0;
        if (valid_o) begin
            if (bypass) begin
                pc_o = inflight_pc_q;
                ir_o = imem_rdata_i;
            end else begin
                pc_o = pc_mem_q[head_q];
                ir_o = ir_mem_q[head_q];
            end
        end
    end

    // Next-state: redirect flushes everything; otherwise fetch, enqueue and pop.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        pc_mem_d      = pc_mem_q;
        ir_mem_d      = ir_mem_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            inflight_d = imem_req_o;
            if (imem_req_o) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_STEP;
            end
            if (enq) begin
                pc_mem_d[tail_q] = inflight_pc_q;
                ir_mem_d[tail_q] = imem_rdata_i;
                tail_d           = tail_q + AW'(1);
            end
            if (pop_queue) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(pop_queue);
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        pc_mem_q <= pc_mem_d;
        ir_mem_q <= ir_mem_d;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: random stimulus against a queue-based reference model of
// the fetch buffer (default DEPTH=4, XLEN=32, RESET_PC=0).
module tb_fetch_buffer;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            halt = 1'b0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            ready = 1'b0;
  logic            rvalid = 1'b0;
  logic [XLEN-1:0] rdata = '0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            valid;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] ir_out;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_o(imem_req),
    .imem_addr_o(imem_addr),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .halt_i(halt),
    .valid_o(valid),
    .pc_o(pc_out),
    .ir_o(ir_out),
    .ready_i(ready)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  logic req_seen = 1'b0;

  // Items decode is expected to consume, in order: {pc, inst}.
  logic [2*XLEN-1:0] exp_q[$];

  // Reference model: fetch pointer, one outstanding request, and an ordered
  // list of fetched but undelivered instructions.
  logic [XLEN-1:0]   m_pc = RESET_PC;
  logic              m_infl = 1'b0;
  logic [XLEN-1:0]   m_ipc = '0;
  logic [2*XLEN-1:0] m_q[$];

  logic            exp_req = 1'b0;
  logic [XLEN-1:0] exp_addr = '0;
  logic            exp_valid = 1'b0;
  logic [XLEN-1:0] exp_pc = '0;
  logic [XLEN-1:0] exp_ir = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Evaluate one cycle of the reference model from the inputs just applied.
  task automatic model_cycle();
    logic live;
    logic byp;
    logic [2*XLEN-1:0] head;
    if (rst) begin
      exp_req = 1'b0;
      exp_valid = 1'b0;
      exp_pc = '0;
      exp_ir = '0;
      m_pc = RESET_PC;
      m_infl = 1'b0;
      m_q.delete();
      return;
    end
    live = m_infl && rvalid;
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (m_q.size() == 0) && !halt && !redirect && live;
`endif
    exp_req = !halt && !redirect && ((m_q.size() + int'(m_infl)) < DEPTH);
    exp_addr = m_pc;
    exp_valid = !halt && ((m_q.size() != 0) || byp);
    if (byp) head = {m_ipc, rdata};
    else if (m_q.size() != 0) head = m_q[0];
    else head = '0;
    exp_pc = exp_valid ? head[2*XLEN-1:XLEN] : '0;
    exp_ir = exp_valid ? head[XLEN-1:0] : '0;
    if (redirect) begin
      m_pc = redirect_pc;
      m_infl = 1'b0;
      m_q.delete();
    end else begin
      if (exp_valid && ready) begin
        exp_q.push_back(head);
        if (!byp) void'(m_q.pop_front());
      end
      if (live && !(byp && ready)) m_q.push_back({m_ipc, rdata});
      m_infl = exp_req;
      if (exp_req) begin
        m_ipc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock: apply inputs, answer last cycle's request (plus occasional
  // unsolicited responses), then advance the model.
  task automatic cyc(input logic r, input logic h, input logic rd,
                     input logic [XLEN-1:0] rp, input logic rdy);
    @(posedge clk);
    #1;
    rst = r;
    halt = h;
    redirect = rd;
    redirect_pc = rp;
    ready = rdy;
    rvalid = req_seen ? 1'b1 : ($urandom_range(0, 7) == 0);
    rdata = $urandom();
    model_cycle();
  endtask

  task automatic run(input int n, input int p_ready, input int p_halt, input int p_redir);
    logic [XLEN-1:0] rp;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      else rp = $urandom() & 32'hFFFF_FFFC;
      cyc(1'b0, $urandom_range(0, 99) < p_halt, $urandom_range(0, 99) < p_redir, rp,
          $urandom_range(0, 99) < p_ready);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2*XLEN-1:0] e;
    if (mon_en) begin
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(exp_addr));
      chk("valid", 64'(valid), 64'(exp_valid));
      if (valid && ready && !redirect && !rst) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got pc %h ir %h expected no delivery", pc_out, ir_out);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", 64'(pc_out), 64'(e[2*XLEN-1:XLEN]));
          chk("pop_ir", 64'(ir_out), 64'(e[XLEN-1:0]));
        end
      end else begin
        chk("pc_out", 64'(pc_out), 64'(exp_pc));
        chk("ir_out", 64'(ir_out), 64'(exp_ir));
      end
    end
    req_seen = imem_req;
  end

  // ---------------- test sequence ----------------
  initial begin
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    mon_en = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    run(20, 100, 0, 0);                     // streaming from reset
    run(12, 0, 0, 0);                       // decode stalled: queue fills
    run(8, 100, 0, 0);                      // drain in order
    cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);   // redirect with request in flight
    run(10, 100, 0, 0);
    run(3, 100, 100, 0);                    // halt with request in flight
    run(10, 100, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1);
    run(10, 100, 0, 0);                     // address wrap
    run(1500, 60, 10, 5);
    repeat (2) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h40, 1'b1);
    run(800, 50, 15, 5);
    run(100, 30, 0, 0);
    @(negedge clk);
    #1;
    chk("undelivered", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
